// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: baud tick, start request and
// payload in, serial line and status out.
interface uart_tx_if #(
  parameter int NB_BITS = 8
);
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_BITS-1:0] i_data;
  logic               o_tx;
  logic               o_tx_done;
  logic               o_busy;

  modport master (
    output i_tick, i_tx_start, i_data,
    input  o_tx, o_tx_done, o_busy
  );

  modport slave (
    input  i_tick, i_tx_start, i_data,
    output o_tx, o_tx_done, o_busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_BITS data bits LSB first, SB_TICK-tick stop,
// all timed by a 16x oversample tick. Every output is a flop.
module uart_tx #(
  parameter int NB_BITS = 8,
  parameter int SB_TICK = 16
) (
  input  logic    i_clk,
  input  logic    i_rst,
  uart_tx_if.slave bus
);
  // Counter is 4 bits for normal bit cells but widens when the stop length exceeds 16 ticks.
  localparam int CNT_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int IDX_W = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(15);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(SB_TICK - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   tick_cnt_r;
  logic [IDX_W-1:0]   bit_idx_r;
  logic [NB_BITS-1:0] shift_r;
  logic [NB_BITS-1:0] shift_next_s;
  logic               tx_r;
  logic               done_r;
  logic               busy_r;

  assign shift_next_s = shift_r >> 1;

  // Frame sequencer; the line level is decided together with each transition.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= '0;
      bit_idx_r  <= '0;
      shift_r    <= '0;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A tick coincident with acceptance is dropped: the counter restarts at 0.
          if (bus.i_tx_start) begin
            shift_r    <= bus.i_data;
            tick_cnt_r <= '0;
            state_r    <= START;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        START: begin
          if (bus.i_tick) begin
            if (tick_cnt_r == BIT_LAST) begin
              tick_cnt_r <= '0;
              bit_idx_r  <= '0;
              state_r    <= DATA;
              tx_r       <= shift_r[0];
            end else begin
              tick_cnt_r <= tick_cnt_r + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (bus.i_tick) begin
            if (tick_cnt_r == BIT_LAST) begin
              tick_cnt_r <= '0;
              shift_r    <= shift_next_s;
              if (bit_idx_r == IDX_LAST) begin
                state_r <= STOP;
                tx_r    <= 1'b1;
              end else begin
                bit_idx_r <= bit_idx_r + IDX_W'(1);
                tx_r      <= shift_next_s[0];
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (bus.i_tick) begin
            if (tick_cnt_r == STOP_LAST) begin
              tick_cnt_r <= '0;
              state_r    <= IDLE;
              done_r     <= 1'b1;
              busy_r     <= 1'b0;
              tx_r       <= 1'b1;
            end else begin
              tick_cnt_r <= tick_cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          tick_cnt_r <= '0;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_tx      = tx_r;
  assign bus.o_tx_done = done_r;
  assign bus.o_busy    = busy_r;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: an 8N1 build and a 7-bit/32-tick-stop build driven with
// identical stimulus, each compared every clock against a line-sample queue model.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if #(.NB_BITS(8)) bus0 ();
  uart_tx_if #(.NB_BITS(7)) bus1 ();

  uart_tx #(.NB_BITS(8), .SB_TICK(16)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
  uart_tx #(.NB_BITS(7), .SB_TICK(32)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

  int nerr = 0;
  int nchk = 0;
  int edge_n = 0;

  // stimulus state
  bit         rst_v = 1'b1;
  bit         st_v = 1'b0;
  bit         tk_v = 1'b0;
  logic [7:0] dat_v = 8'h00;
  int         div = 1;
  int         ph = 0;

  // reference model: expected line level for every tick of the frame in flight
  int nb_m [2] = '{8, 7};
  int sb_m [2] = '{16, 32};
  bit lvl_m [2][256];
  int len_m [2];
  int pos_m [2];
  bit etx [2] = '{1'b1, 1'b1};
  bit edone [2] = '{1'b0, 1'b0};
  bit ebusy [2] = '{1'b0, 1'b0};

  int done_cnt [2] = '{0, 0};
  int done_edge [2] = '{0, 0};

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         restart;
    logic [7:0] mid;
    int         frame_clks;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic model_edge(input int k);
    int n;
    if (rst_v) begin
      len_m[k] = 0; pos_m[k] = 0;
      etx[k] = 1'b1; edone[k] = 1'b0; ebusy[k] = 1'b0;
    end else if (!ebusy[k]) begin
      edone[k] = 1'b0;
      if (st_v) begin
        n = 0;
        for (int j = 0; j < 16; j++) begin lvl_m[k][n] = 1'b0; n++; end
        for (int b = 0; b < nb_m[k]; b++)
          for (int j = 0; j < 16; j++) begin lvl_m[k][n] = dat_v[b]; n++; end
        for (int j = 0; j < sb_m[k]; j++) begin lvl_m[k][n] = 1'b1; n++; end
        len_m[k] = n; pos_m[k] = 0;
        etx[k] = lvl_m[k][0]; ebusy[k] = 1'b1;
      end else begin
        etx[k] = 1'b1;
      end
    end else begin
      edone[k] = 1'b0;
      if (tk_v) begin
        pos_m[k]++;
        if (pos_m[k] == len_m[k]) begin
          ebusy[k] = 1'b0; edone[k] = 1'b1; etx[k] = 1'b1;
        end else begin
          etx[k] = lvl_m[k][pos_m[k]];
        end
      end
    end
  endtask

  task automatic cyc();
    bus0.i_tx_start = st_v; bus1.i_tx_start = st_v;
    bus0.i_data = dat_v;    bus1.i_data = dat_v[6:0];
    bus0.i_tick = tk_v;     bus1.i_tick = tk_v;
    rst = rst_v;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("tx0",   32'(bus0.o_tx),      32'(etx[0]));
    chk("done0", 32'(bus0.o_tx_done), 32'(edone[0]));
    chk("busy0", 32'(bus0.o_busy),    32'(ebusy[0]));
    chk("tx1",   32'(bus1.o_tx),      32'(etx[1]));
    chk("done1", 32'(bus1.o_tx_done), 32'(edone[1]));
    chk("busy1", 32'(bus1.o_busy),    32'(ebusy[1]));
    if (bus0.o_tx_done) begin done_cnt[0]++; done_edge[0] = edge_n; end
    if (bus1.o_tx_done) begin done_cnt[1]++; done_edge[1] = edge_n; end
    edge_n++;
  endtask

  task automatic cyc_gen();
    tk_v = (ph == 0);
    ph = (ph + 1 >= div) ? 0 : ph + 1;
    cyc();
  endtask

  task automatic wait_idle();
    st_v = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!bus0.o_busy && !bus1.o_busy) break;
      cyc_gen();
    end
    chk("idle_wait", 32'(bus0.o_busy | bus1.o_busy), 32'd0);
  endtask

  initial begin
    int acc, d0, d1, rel, per;
    logic [7:0] dec0, dec1;
    int de0 [3];
    int de1 [3];
    int n0, n1;

    tbl[0] = '{8'h35, 1, 1'b0, 8'h00, 160, 8'h35, 8'hB5};
    tbl[1] = '{8'hFF, 4, 1'b0, 8'h00, 640, 8'hFF, 8'hFF};
    tbl[2] = '{8'h35, 1, 1'b1, 8'h00, 160, 8'h35, 8'hB5};
    tbl[3] = '{8'hA5, 2, 1'b0, 8'h00, 320, 8'hA5, 8'hA5};
    tbl[4] = '{8'h00, 3, 1'b1, 8'hFF, 480, 8'h00, 8'h80};

    // reset overrides a pending start
    rst_v = 1'b1; st_v = 1'b1; dat_v = 8'h3C; div = 1; ph = 0;
    repeat (3) cyc_gen();
    chk("rst_tx0",   32'(bus0.o_tx), 32'd1);
    chk("rst_busy0", 32'(bus0.o_busy), 32'd0);
    chk("rst_done0", 32'(bus0.o_tx_done), 32'd0);
    chk("rst_tx1",   32'(bus1.o_tx), 32'd1);
    // first edge out of reset accepts the held start
    rst_v = 1'b0;
    cyc_gen();
    chk("first_accept_busy", 32'(bus0.o_busy), 32'd1);
    chk("first_accept_tx",   32'(bus0.o_tx), 32'd0);
    wait_idle();

    // directed frames from the table
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      div = tbl[i].div; ph = 0;
      st_v = 1'b1; dat_v = tbl[i].data;
      cyc_gen();
      st_v = 1'b0;
      acc = edge_n - 1;
      d0 = done_cnt[0]; d1 = done_cnt[1];
      dec0 = 8'h00; dec1 = 8'h00;
      per = 16 * div;
      for (int c = 0; c < 200 * tbl[i].div; c++) begin
        cyc_gen();
        rel = edge_n - 1 - acc;
        if ((rel % per) == per / 2 && rel / per >= 1 && rel / per <= 8) begin
          dec0[rel / per - 1] = bus0.o_tx;
          dec1[rel / per - 1] = bus1.o_tx;
        end
        if (tbl[i].restart && rel == 49) begin st_v = 1'b1; dat_v = tbl[i].mid; end
        if (rel == 50) st_v = 1'b0;
        if (done_cnt[0] != d0 && done_cnt[1] != d1) break;
      end
      chk($sformatf("frame_len0[%0d]", i), 32'(done_edge[0] - acc), 32'(tbl[i].frame_clks));
      chk($sformatf("frame_len1[%0d]", i), 32'(done_edge[1] - acc), 32'(tbl[i].frame_clks));
      chk($sformatf("bits0[%0d]", i), 32'(dec0), 32'(tbl[i].exp0));
      chk($sformatf("bits1[%0d]", i), 32'(dec1), 32'(tbl[i].exp1));
      chk($sformatf("ndone0[%0d]", i), 32'(done_cnt[0] - d0), 32'd1);
      chk($sformatf("ndone1[%0d]", i), 32'(done_cnt[1] - d1), 32'd1);
    end

    // start held high: back-to-back frames one idle clock apart
    wait_idle();
    div = 1; ph = 0; st_v = 1'b1; dat_v = 8'hA5;
    n0 = 0; n1 = 0; d0 = done_cnt[0]; d1 = done_cnt[1];
    for (int c = 0; c < 600 && (n0 < 3 || n1 < 3); c++) begin
      cyc_gen();
      if (done_cnt[0] != d0) begin if (n0 < 3) de0[n0] = done_edge[0]; n0++; d0 = done_cnt[0]; end
      if (done_cnt[1] != d1) begin if (n1 < 3) de1[n1] = done_edge[1]; n1++; d1 = done_cnt[1]; end
    end
    chk("b2b_frames0", 32'(n0), 32'd3);
    chk("b2b_gap0a", 32'(de0[1] - de0[0]), 32'd161);
    chk("b2b_gap0b", 32'(de0[2] - de0[1]), 32'd161);
    chk("b2b_gap1a", 32'(de1[1] - de1[0]), 32'd161);
    st_v = 1'b0;
    wait_idle();

    // reset 80 clocks into a frame aborts it silently
    div = 1; ph = 0; st_v = 1'b1; dat_v = 8'h35;
    cyc_gen();
    st_v = 1'b0;
    repeat (79) cyc_gen();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    rst_v = 1'b1;
    cyc_gen();
    rst_v = 1'b0;
    chk("abort_tx0",   32'(bus0.o_tx), 32'd1);
    chk("abort_busy0", 32'(bus0.o_busy), 32'd0);
    chk("abort_busy1", 32'(bus1.o_busy), 32'd0);
    repeat (200) cyc_gen();
    chk("abort_nodone0", 32'(done_cnt[0] - d0), 32'd0);
    chk("abort_nodone1", 32'(done_cnt[1] - d1), 32'd0);
    ph = 0; st_v = 1'b1; dat_v = 8'h5A;
    cyc_gen();
    st_v = 1'b0;
    acc = edge_n - 1;
    for (int c = 0; c < 200 && done_cnt[0] == d0; c++) cyc_gen();
    chk("after_abort_len", 32'(done_edge[0] - acc), 32'd160);

    // random traffic, ticks and occasional resets against the model
    for (int c = 0; c < 3000; c++) begin
      tk_v  = ($urandom_range(0, 2) == 0);
      st_v  = ($urandom_range(0, 19) == 0);
      dat_v = 8'($urandom);
      rst_v = ($urandom_range(0, 699) == 0);
      cyc();
    end
    rst_v = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 Parameter NB_BITS, default 8: data bits per frame.
- REQ-002 Parameter SB_TICK, default 16: stop-bit length in i_tick pulses (16 = 1 stop bit).
- REQ-003 i_clk  input  1: single clock; all logic on rising edge.
- REQ-004 i_rst  input  1: reset, synchronous and active-high.
- REQ-005 i_tick  input  1: 16x-oversample baud tick from the baud-rate generator; one-cycle pulse.
- REQ-006 i_tx_start  input  1: request to send i_data; level-sampled.
- REQ-007 i_data  input  NB_BITS: byte to transmit.
- REQ-008 o_tx  output  1: serial line, idle high.
- REQ-009 o_tx_done  output  1: one-cycle pulse at frame end.
- REQ-010 o_busy  output  1: high while a frame is in progress.

Function
- REQ-011 The block SHALL implement an FSM with states IDLE, START, DATA and STOP, a 4-bit tick counter, a bit index, and an NB_BITS shift register.
- REQ-012 o_tx SHALL be registered and glitch-free, and SHALL equal 1 in IDLE and STOP, 0 in START, and shift_reg[0] in DATA.
- REQ-013 IDLE: on an edge with i_tx_start=1, the block SHALL latch i_data, clear the tick counter and enter START; o_tx SHALL fall on that same edge.
- REQ-014 In START, DATA and STOP, the tick counter SHALL advance only on cycles with i_tick=1; cycles without a tick SHALL hold all state.
- REQ-015 START: on the 16th tick, the block SHALL enter DATA with bit index 0 and tick counter 0.
- REQ-016 DATA: on every 16th tick, the block SHALL shift the register right (LSB first) and increment the bit index; after bit NB_BITS-1 it SHALL enter STOP.
- REQ-017 STOP: on the SB_TICK-th tick, the block SHALL enter IDLE and assert o_tx_done for exactly that one cycle.
- REQ-018 A frame SHALL last (1+NB_BITS)*16+SB_TICK ticks; each bit SHALL last exactly 16 ticks.
- REQ-019 o_busy SHALL be high in every state except IDLE; it SHALL rise on the edge that accepts a start and fall on the edge that asserts o_tx_done.
- REQ-020 While busy, i_tx_start SHALL be ignored; changes on i_data SHALL NOT affect the frame in flight.
- REQ-021 i_tx_start high on the o_tx_done cycle SHALL NOT be accepted, because the FSM is still in STOP on that edge; it SHALL be accepted on the next edge in IDLE, giving a minimum 1-cycle inter-frame gap.
- REQ-022 A start held high continuously SHALL produce back-to-back frames separated by exactly 1 clock of idle-high line.
- REQ-023 An i_tick coincident with acceptance of i_tx_start SHALL NOT be counted.

Reset
- REQ-024 With i_rst=1 at an edge, the block SHALL return to IDLE: o_tx=1, o_tx_done=0, o_busy=0, counters and shift register 0.
- REQ-025 Reset SHALL override i_tx_start and any in-flight frame; an aborted frame SHALL produce no o_tx_done, and o_tx SHALL return high on the reset edge.
- REQ-026 After reset deasserts, the first start SHALL be accepted no earlier than the first edge with i_rst=0.

Verification
- REQ-027 i_tick=1 constantly, i_data=0x35, 1-cycle start -> o_tx low for 16 cycles, then 1,0,1,0,1,1,0,0 for 16 cycles each, then high for 16; o_tx_done pulses at cycle 160; o_busy high cycles 1-160.
- REQ-028 i_tick pulsing every 4 clocks, i_data=0xFF -> each bit lasts 64 clocks, frame 640 clocks, exactly one o_tx_done.
- REQ-029 Start pulsed again at cycle 50 with i_data changed to 0x00 during frame 0x35 -> ignored; serial pattern unchanged; one done pulse.
- REQ-030 i_tx_start held high, i_data=0xA5 -> consecutive frames each 160 cycles, exactly 1 idle-high cycle between them, done pulse per frame.
- REQ-031 i_rst asserted at cycle 80 of a frame -> o_tx=1, o_busy=0 next edge, no o_tx_done; new start afterwards yields a complete correct frame.
- REQ-032 NB_BITS=7, SB_TICK=32 build -> frame 8*16+32=160 ticks, stop-high lasts 32 ticks.
